gsim_x_collector: RTL and testbench
===================================

// Module: gsim_x_collector
// PURPOSE
//  Downstream of the GSIM solver. Captures each N-word x burst (x_valid/x_in) into one of two
//  banks (ping-pong) and drains it to the host over a valid/ready stream with index and last.
//  Provides solve_ok so the upstream b loader never starts a solve whose result would be dropped.
// PARAMETERS
//  N        16  words per solution burst (power of 2, >=2)
//  XW       32  x word width, signed Q16.16
//  IW        4  index width = clog2(N)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  reset      in   1   synchronous, active-high; clears all state
//  x_valid    in   1   solver out_valid; a burst is one contiguous high run
//  x_in       in   XW  solver x_out, word k on k-th high cycle of the run
//  m_valid    out  1   output word valid
//  m_ready    in   1   host accepts word when m_valid&&m_ready
//  m_data     out  XW  output word
//  m_index    out  IW  word index 0..N-1 within the solution
//  m_last     out  1   high with index N-1
//  solve_ok   out  1   at least one bank empty (free to start a solve)
//  err_short  out  1   sticky: burst ended with fewer than N words
//  err_ovf    out  1   sticky: burst arrived with no free bank
// BEHAVIOUR
//  Reset: m_valid=0, m_index=0, m_last=0, m_data=0, solve_ok=1, err_short=0, err_ovf=0;
//   both banks empty, write bank=0, read bank=0; a burst in flight at reset is discarded.
//  Capture FSM: C_IDLE -> (x_valid, free bank) C_CAP; (x_valid, none free) C_DROP, set err_ovf.
//   C_CAP: write x_in at wr_cnt, wr_cnt++ each x_valid cycle. On the N-th word mark bank
//    full, toggle write bank, -> C_SKIP. x_valid low before N words: bank stays empty,
//    set err_short, -> C_IDLE.
//   C_SKIP/C_DROP: ignore words until x_valid low -> C_IDLE. Extra words (solver emits N+1)
//    are discarded, not errors.
//  Drain FSM: D_IDLE -> D_SEND when read bank full. D_SEND presents word rd_cnt; rd_cnt
//   advances only on m_valid&&m_ready; m_data/m_index stable while stalled. After word N-1
//   accepted: read bank empty, toggle read bank, D_SEND again if other bank full (no bubble)
//   else D_IDLE.
//  Latency: last captured word at cycle t -> m_valid high at t+1 (registered outputs).
//  Simultaneous bank full (capture) and bank empty (drain) in same cycle: both take effect;
//   a burst starting that cycle sees the freed bank as free.
//  solve_ok = !(full0 && full1), registered, updated same cycle as full flags.
//  Errors clear only on reset. Counters wrap mod N; no other arithmetic.
// CONFIGURATION
//  GSIM_XC_ROUND16_EN defined: m_data = sign-extended int16 of round-half-up(x[31:16]+x[15]),
//   saturated to [-32768,32767]; applied on read path, banks store full XW.
//  Undefined: m_data = stored XW word unmodified.
// STRUCTURE
//  Shared package/header gsim_pkg: N, XW, IW, capture/drain state encodings,
//   Q16.16 FRAC_BITS=16.
//  One sub-module: gsim_xbank (N x XW register bank, 1 write port, 1 async read port),
//   instantiated twice.
// TESTING
//  Burst x_in=k<<16 k=0..15, m_ready=1 -> m_data 0..15<<16 at t+1..t+16, m_last at idx 15.
//  17-cycle burst -> 16 words out, 17th dropped, err_short=0.
//  Burst of 10 words -> no m_valid, err_short=1, next full burst drains normally.
//  m_ready=0 during 3 bursts -> bursts 1,2 held, solve_ok=0 after 2, burst 3 sets err_ovf;
//   release -> 32 words back-to-back, no bubble.
//  m_ready toggling 1010... -> each word held stable until accepted, order preserved.
//  Reset at word 8 of a burst -> outputs at reset values next cycle, no m_valid.
//  ROUND16_EN: x=0x0001_8000 -> 2; 0xFFFF_7FFF -> -1; 0x7FFF_8000 -> 32767.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared definitions for the GSIM x collector: sizes, FSM encodings, output beat
// payload and the Q16.16 -> int16 rounding helper used on the optional read path.
package gsim_pkg;

    localparam int unsigned N         = 16;  // words per solution burst
    localparam int unsigned XW        = 32;  // x word width, signed Q16.16
    localparam int unsigned IW        = 4;   // clog2(N)
    localparam int unsigned FRAC_BITS = 16;  // Q16.16 fraction bits

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_CAP  = 2'd1,
        C_SKIP = 2'd2,
        C_DROP = 2'd3
    } cap_state_e;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_SEND = 1'b1
    } drn_state_e;

    // One word presented on the host stream
    typedef struct packed {
        logic [XW-1:0] data;
        logic [IW-1:0] index;
        logic          last;
    } m_beat_t;

    // Round-half-up of the integer part, saturated to int16, sign-extended to XW.
    // Only +1 can be added, so the single overflow case is 32767 + 1.
    function automatic logic [XW-1:0] round16(input logic [XW-1:0] x);
        logic [16:0] sum;
        logic [15:0] sat;
        sum = {x[XW-1], x[XW-1:FRAC_BITS]} + {16'd0, x[FRAC_BITS-1]};
        if (!sum[16] && sum[15]) begin
            sat = 16'h7FFF;
        end else begin
            sat = sum[15:0];
        end
        return {{(XW-16){sat[15]}}, sat};
    endfunction

endpackage

// File: rtl/gsim_xbank.sv
// One solution bank: N x XW registers, one synchronous write port and one
// asynchronous read port.
//  clk     in  clock
//  we      in  write enable
//  waddr   in  write word index
//  wdata   in  write data
//  raddr   in  read word index
//  rdata_c out read data (combinational from raddr)
module gsim_xbank
    import gsim_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [XW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [XW-1:0] rdata_c
);

    logic [XW-1:0] mem_q [N];

    // Storage; contents are only read once the bank is marked full, so no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/gsim_x_collector.sv
// GSIM x collector: captures each N-word solver burst into one of two ping-pong
// banks and drains it to the host over a valid/ready stream with index/last.
// solve_ok tells the b loader a bank is free so no solve result gets dropped.
// Optional feature: define GSIM_XC_ROUND16_EN to emit int16 round-half-up,
// saturated, sign-extended words instead of the raw Q16.16 words.
//  clk       in   clock, rising edge
//  reset     in   synchronous active-high reset
//  x_valid   in   solver word valid (one contiguous run per burst)
//  x_in      in   solver word
//  m_valid   out  output word valid
//  m_ready   in   host ready
//  m_data    out  output word
//  m_index   out  word index within solution
//  m_last    out  high with index N-1
//  solve_ok  out  at least one bank empty
//  err_short out  sticky: burst shorter than N words
//  err_ovf   out  sticky: burst arrived with no free bank
module gsim_x_collector
    import gsim_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    input  logic [XW-1:0] x_in,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [XW-1:0] m_data,
    output logic [IW-1:0] m_index,
    output logic          m_last,
    output logic          solve_ok,
    output logic          err_short,
    output logic          err_ovf
);

    cap_state_e    cap_q,       cap_d;
    logic [IW-1:0] wr_cnt_q,    wr_cnt_d;
    logic          wr_bank_q,   wr_bank_d;
    logic [1:0]    full_q,      full_d;
    drn_state_e    drn_q,       drn_d;
    logic [IW-1:0] rd_cnt_q,    rd_cnt_d;
    logic          rd_bank_q,   rd_bank_d;
    m_beat_t       beat_q,      beat_d;
    logic          m_valid_q,   m_valid_d;
    logic          solve_ok_q,  solve_ok_d;
    logic          err_short_q, err_short_d;
    logic          err_ovf_q,   err_ovf_d;

    logic          full_set;
    logic          full_clr;
    logic          bank_free;
    logic          wr_en;
    logic [XW-1:0] rdata0;
    logic [XW-1:0] rdata1;
    logic [XW-1:0] rd_word;
    logic [XW-1:0] rd_fmt;

    gsim_xbank u_bank0 (
        .clk     (clk),
        .we      (wr_en && !wr_bank_q),
        .waddr   (wr_cnt_q),
        .wdata   (x_in),
        .raddr   (rd_cnt_d),
        .rdata_c (rdata0)
    );

    gsim_xbank u_bank1 (
        .clk     (clk),
        .we      (wr_en && wr_bank_q),
        .waddr   (wr_cnt_q),
        .wdata   (x_in),
        .raddr   (rd_cnt_d),
        .rdata_c (rdata1)
    );

    // Last word of the read bank accepted this cycle
    always_comb begin
        full_clr = (drn_q == D_SEND) && m_valid_q && m_ready && (rd_cnt_q == IW'(N - 1));
    end

    // A bank being freed by the drain this cycle already counts as free
    always_comb begin
        bank_free = !full_q[wr_bank_q] || (full_clr && (rd_bank_q == wr_bank_q));
    end

    // Capture FSM next state
    always_comb begin
        cap_d       = cap_q;
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        full_set    = 1'b0;
        wr_en       = 1'b0;
        err_short_d = err_short_q;
        err_ovf_d   = err_ovf_q;
        case (cap_q)
            C_IDLE: begin
                if (x_valid) begin
                    if (bank_free) begin
                        wr_en    = 1'b1;
                        wr_cnt_d = IW'(1);
                        cap_d    = C_CAP;
                    end else begin
                        err_ovf_d = 1'b1;
                        cap_d     = C_DROP;
                    end
                end
            end
            C_CAP: begin
                if (x_valid) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == IW'(N - 1)) begin
                        full_set  = 1'b1;
                        wr_bank_d = ~wr_bank_q;
                        wr_cnt_d  = '0;
                        cap_d     = C_SKIP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IW'(1);
                    end
                end else begin
                    err_short_d = 1'b1;
                    wr_cnt_d    = '0;
                    cap_d       = C_IDLE;
                end
            end
            C_SKIP, C_DROP: begin
                if (!x_valid) begin
                    cap_d = C_IDLE;
                end
            end
            default: begin
                cap_d = C_IDLE;
            end
        endcase
    end

    // Bank occupancy; set and clear never target the same bank in one cycle
    always_comb begin
        full_d = full_q;
        if (full_clr) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (full_set) begin
            full_d[wr_bank_q] = 1'b1;
        end
        solve_ok_d = !(full_d[0] && full_d[1]);
    end

    // Drain FSM next state; looks at next-cycle occupancy so m_valid rises
    // together with the full flag and back-to-back banks leave no bubble
    always_comb begin
        drn_d     = drn_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        case (drn_q)
            D_IDLE: begin
                if (full_d[rd_bank_q]) begin
                    drn_d    = D_SEND;
                    rd_cnt_d = '0;
                end
            end
            D_SEND: begin
                if (m_ready) begin
                    if (rd_cnt_q == IW'(N - 1)) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_cnt_d  = '0;
                        drn_d     = full_d[~rd_bank_q] ? D_SEND : D_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + IW'(1);
                    end
                end
            end
            default: begin
                drn_d = D_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_word = rd_bank_d ? rdata1 : rdata0;
    end

`ifdef GSIM_XC_ROUND16_EN
    always_comb begin
        rd_fmt = round16(rd_word);
    end
`else
    always_comb begin
        rd_fmt = rd_word;
    end
`endif

    // Output beat for next cycle; data holds its last value while idle
    always_comb begin
        m_valid_d    = (drn_d == D_SEND);
        beat_d.index = rd_cnt_d;
        beat_d.last  = m_valid_d && (rd_cnt_d == IW'(N - 1));
        beat_d.data  = m_valid_d ? rd_fmt : beat_q.data;
    end

    // State registers; capture resets into SKIP so a burst in flight is discarded
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q       <= C_SKIP;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= '0;
            drn_q       <= D_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            beat_q      <= '0;
            m_valid_q   <= 1'b0;
            solve_ok_q  <= 1'b1;
            err_short_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            cap_q       <= cap_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            drn_q       <= drn_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            beat_q      <= beat_d;
            m_valid_q   <= m_valid_d;
            solve_ok_q  <= solve_ok_d;
            err_short_q <= err_short_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = beat_q.data;
    assign m_index   = beat_q.index;
    assign m_last    = beat_q.last;
    assign solve_ok  = solve_ok_q;
    assign err_short = err_short_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_gsim_x_collector.sv
// Self-checking bench for gsim_x_collector: expected words are queued as bursts
// are driven and popped when the host accepts them.
module tb_gsim_x_collector;
    import gsim_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          x_valid;
    logic [XW-1:0] x_in;
    logic          m_valid;
    logic          m_ready;
    logic [XW-1:0] m_data;
    logic [IW-1:0] m_index;
    logic          m_last;
    logic          solve_ok;
    logic          err_short;
    logic          err_ovf;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  i;
        logic        l;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    gsim_x_collector dut (
        .clk       (clk),
        .reset     (reset),
        .x_valid   (x_valid),
        .x_in      (x_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_last    (m_last),
        .solve_ok  (solve_ok),
        .err_short (err_short),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference read-path format
    function automatic logic [31:0] exp_fmt(input logic [31:0] x);
`ifdef GSIM_XC_ROUND16_EN
        int v;
        v = int'($signed(x[31:16])) + (x[15] ? 1 : 0);
        if (v > 32767) v = 32767;
        return 32'(v);
`else
        return x;
`endif
    endfunction

    // mode 0: k<<16, mode 1: random, mode 2: rounding corner vectors then k<<16
    function automatic logic [31:0] word_for(input int mode, input int k);
        logic [31:0] vec [3];
        vec[0] = 32'h0001_8000;
        vec[1] = 32'hFFFF_7FFF;
        vec[2] = 32'h7FFF_8000;
        if (mode == 1) return $urandom;
        if (mode == 2 && k < 3) return vec[k];
        return 32'(k) << 16;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive an n-word burst; kept bursts queue their first N words
    task automatic burst(input int n, input int mode, input bit keep);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            x_valid = 1'b1;
            x_in    = word_for(mode, k);
            if (keep && k < N) begin
                e.d = exp_fmt(x_in);
                e.i = 4'(k);
                e.l = (k == N - 1);
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        x_in    = '0;
    endtask

    task automatic wait_drain(input string tag);
        int c = 0;
        while (sb_q.size() != 0 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
        idle(3);
    endtask

    // Output monitor: every valid word is compared against the queue head;
    // while stalled the same head is compared again, so the word must hold.
    always @(negedge clk) begin
        if (!reset && m_valid) begin
            if (sb_q.size() == 0) begin
                check("valid_with_nothing_expected", 32'(m_valid), 32'd0);
            end else begin
                check("m_data",  m_data,          sb_q[0].d);
                check("m_index", 32'(m_index),    32'(sb_q[0].i));
                check("m_last",  32'(m_last),     32'(sb_q[0].l));
                if (m_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset   = 1'b1;
        x_valid = 1'b0;
        x_in    = '0;
        m_ready = 1'b1;
        idle(3);
        reset = 1'b0;

        // Reset values
        check("rst_m_valid",   32'(m_valid),   32'd0);
        check("rst_m_index",   32'(m_index),   32'd0);
        check("rst_m_last",    32'(m_last),    32'd0);
        check("rst_m_data",    m_data,         32'd0);
        check("rst_solve_ok",  32'(solve_ok),  32'd1);
        check("rst_err_short", 32'(err_short), 32'd0);
        check("rst_err_ovf",   32'(err_ovf),   32'd0);
        idle(2);

        // Basic burst with one-cycle latency
        burst(16, 0, 1'b1);
        check("lat_m_valid", 32'(m_valid), 32'd1);
        check("lat_m_index", 32'(m_index), 32'd0);
        check("lat_m_data",  m_data,       exp_fmt(32'd0));
        wait_drain("drain_basic");

        // 17-word burst: extra word silently dropped
        burst(17, 0, 1'b1);
        wait_drain("drain_17");
        check("err_short_after_17", 32'(err_short), 32'd0);

        // Short burst: nothing out, sticky error, next burst normal
        burst(10, 0, 1'b0);
        idle(20);
        check("err_short_after_10", 32'(err_short), 32'd1);
        check("m_valid_after_10",   32'(m_valid),   32'd0);
        burst(16, 1, 1'b1);
        wait_drain("drain_after_short");

        // Backpressure: two bursts held, third overflows
        m_ready = 1'b0;
        burst(16, 0, 1'b1);
        check("solve_ok_one_full", 32'(solve_ok), 32'd1);
        idle(2);
        burst(16, 1, 1'b1);
        check("solve_ok_two_full", 32'(solve_ok), 32'd0);
        idle(2);
        check("err_ovf_before", 32'(err_ovf), 32'd0);
        burst(16, 1, 1'b0);
        check("err_ovf_after", 32'(err_ovf), 32'd1);
        check("solve_ok_still_0", 32'(solve_ok), 32'd0);
        m_ready = 1'b1;
        cnt = 0;
        repeat (32) begin
            @(negedge clk);
            if (m_valid) cnt++;
        end
        check("no_bubble_32", 32'(cnt), 32'd32);
        wait_drain("drain_ovf");
        check("solve_ok_released", 32'(solve_ok), 32'd1);

        // Toggling ready across two random bursts
        fork
            begin
                burst(16, 1, 1'b1);
                burst(16, 1, 1'b1);
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    m_ready = ~m_ready;
                end
            end
        join
        m_ready = 1'b1;
        wait_drain("drain_toggle");

        // Reset during word 8 of a burst
        check("err_ovf_sticky", 32'(err_ovf), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            x_valid = 1'b1;
            x_in    = word_for(0, k);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        x_in  = word_for(0, 8);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_m_valid",   32'(m_valid),   32'd0);
        check("mid_rst_m_index",   32'(m_index),   32'd0);
        check("mid_rst_m_last",    32'(m_last),    32'd0);
        check("mid_rst_m_data",    m_data,         32'd0);
        check("mid_rst_solve_ok",  32'(solve_ok),  32'd1);
        check("mid_rst_err_short", 32'(err_short), 32'd0);
        check("mid_rst_err_ovf",   32'(err_ovf),   32'd0);
        x_in = word_for(0, 9);
        for (int k = 10; k < 16; k++) begin
            @(posedge clk);
            #1;
            x_in = word_for(0, k);
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        idle(20);
        check("tail_err_short", 32'(err_short), 32'd0);
        check("tail_m_valid",   32'(m_valid),   32'd0);

        // Rounding corner vectors (raw in default build)
        burst(16, 2, 1'b1);
        wait_drain("drain_round");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
